// File: rtl/merge_board_seq.sv
// Sequential 2048-style board merger: slides and merges one row/column per clock.
// Define MERGE_SCORE_EN to implement the merge accumulator and merge_cnt output.
module merge_board_seq #(
    parameter  int SIZE   = 4,
    parameter  int TILE_W = 5,
    localparam int CNT_W  = $clog2(SIZE*SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SIZE*SIZE*TILE_W-1:0] board_in,
    input  logic [1:0]                  movDir,
    output logic                        busy,
    output logic                        done,
    output logic                        movable,
    output logic [SIZE*SIZE*TILE_W-1:0] board_after,
    output logic [CNT_W-1:0]            merge_cnt
);

    localparam int NT    = SIZE * SIZE;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef logic [TILE_W-1:0]         tile_t;
    typedef logic [SIZE-1:0][TILE_W-1:0] line_t;
    typedef logic [NT-1:0][TILE_W-1:0]   board_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       dir_q, dir_d;
    board_t           cap_q, cap_d;
    board_t           work_q, work_d;
    board_t           board_after_q, board_after_d;
    logic             movable_q, movable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef MERGE_SCORE_EN
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;
`endif

    line_t  line_in;
    line_t  line_out;
    board_t work_line;

    // Board index of the j-th tile of line ln, counting outward from the target edge.
    function automatic int tile_idx(input logic [1:0] dir, input int ln, input int j);
        int r;
        int c;
        case (dir)
            2'd0:    begin r = ln;         c = j;            end
            2'd1:    begin r = ln;         c = SIZE - 1 - j; end
            2'd2:    begin r = j;          c = ln;           end
            default: begin r = SIZE - 1 - j; c = ln;         end
        endcase
        return r * SIZE + c;
    endfunction

    // Saturated tiles never merge: k+1 would not fit in TILE_W bits.
    function automatic logic can_merge(input tile_t a, input tile_t b);
        return (a == b) && (a != {TILE_W{1'b1}});
    endfunction

    function automatic line_t put_tile(input line_t l, input int pos, input tile_t v);
        line_t res;
        res = l;
        for (int k = 0; k < SIZE; k++) begin
            if (k == pos) res[k] = v;
        end
        return res;
    endfunction

    // A tile is held as pending until the next nonzero tile decides merge or emit,
    // which gives first-pair-from-target priority and at most one merge per tile.
    function automatic line_t merge_line(input line_t src);
        line_t res;
        tile_t pend;
        logic  pend_vld;
        int    wr;
        res      = '0;
        pend     = '0;
        pend_vld = 1'b0;
        wr       = 0;
        for (int j = 0; j < SIZE; j++) begin
            if (src[j] != '0) begin
                if (pend_vld && can_merge(pend, src[j])) begin
                    res      = put_tile(res, wr, pend + 1'b1);
                    wr       = wr + 1;
                    pend_vld = 1'b0;
                end else begin
                    if (pend_vld) begin
                        res = put_tile(res, wr, pend);
                        wr  = wr + 1;
                    end
                    pend     = src[j];
                    pend_vld = 1'b1;
                end
            end
        end
        if (pend_vld) res = put_tile(res, wr, pend);
        return res;
    endfunction

`ifdef MERGE_SCORE_EN
    function automatic logic [CNT_W-1:0] count_tiles(input line_t l);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int j = 0; j < SIZE; j++) begin
            if (l[j] != '0) n = n + 1'b1;
        end
        return n;
    endfunction
`endif

    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            line_in[j] = '0;
            for (int p = 0; p < NT; p++) begin
                if (p == tile_idx(dir_q, int'(idx_q), j)) line_in[j] = work_q[p];
            end
        end
        line_out  = merge_line(line_in);
        work_line = work_q;
        for (int p = 0; p < NT; p++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (p == tile_idx(dir_q, int'(idx_q), j)) work_line[p] = line_out[j];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dir_d         = dir_q;
        cap_d         = cap_q;
        work_d        = work_q;
        board_after_d = board_after_q;
        movable_d     = movable_q;
        busy_d        = 1'b0;
        done_d        = 1'b0;
`ifdef MERGE_SCORE_EN
        acc_d         = acc_q;
        merge_cnt_d   = merge_cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    dir_d   = movDir;
                    cap_d   = board_t'(board_in);
                    work_d  = board_t'(board_in);
`ifdef MERGE_SCORE_EN
                    acc_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d = work_line;
                busy_d = 1'b1;
                idx_d  = idx_q + 1'b1;
`ifdef MERGE_SCORE_EN
                acc_d  = acc_q + count_tiles(line_in) - count_tiles(line_out);
`endif
                if (idx_q == LAST_IDX) begin
                    state_d       = DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    board_after_d = work_line;
                    movable_d     = (work_line != cap_q);
`ifdef MERGE_SCORE_EN
                    merge_cnt_d   = acc_d;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            dir_q         <= '0;
            cap_q         <= '0;
            work_q        <= '0;
            board_after_q <= '0;
            movable_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef MERGE_SCORE_EN
            acc_q         <= '0;
            merge_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dir_q         <= dir_d;
            cap_q         <= cap_d;
            work_q        <= work_d;
            board_after_q <= board_after_d;
            movable_q     <= movable_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef MERGE_SCORE_EN
            acc_q         <= acc_d;
            merge_cnt_q   <= merge_cnt_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign movable     = movable_q;
    assign board_after = board_after_q;
`ifdef MERGE_SCORE_EN
    assign merge_cnt   = merge_cnt_q;
`else
    assign merge_cnt   = '0;
`endif

endmodule

// File: tb/tb_merge_board_seq.sv
// Directed self-checking bench for merge_board_seq (SIZE=4 and SIZE=3 instances).
module tb_merge_board_seq;

    localparam int TW  = 5;
    localparam int BW4 = 16 * TW;
    localparam int BW3 = 9 * TW;
`ifdef MERGE_SCORE_EN
    localparam bit SCORE = 1'b1;
`else
    localparam bit SCORE = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic [BW4-1:0] board_in;
    logic [1:0]     mov_dir;
    logic           busy;
    logic           done;
    logic           movable;
    logic [BW4-1:0] board_after;
    logic [3:0]     merge_cnt;

    logic           start3;
    logic [BW3-1:0] board_in3;
    logic [1:0]     mov_dir3;
    logic           busy3;
    logic           done3;
    logic           movable3;
    logic [BW3-1:0] board_after3;
    logic [3:0]     merge_cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW4-1:0] brd_a;
    logic [BW4-1:0] exp_left;
    logic [BW4-1:0] exp_right;

    merge_board_seq #(.SIZE(4), .TILE_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .board_in(board_in), .movDir(mov_dir),
        .busy(busy), .done(done), .movable(movable), .board_after(board_after),
        .merge_cnt(merge_cnt)
    );

    merge_board_seq #(.SIZE(3), .TILE_W(TW)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .board_in(board_in3), .movDir(mov_dir3),
        .busy(busy3), .done(done3), .movable(movable3), .board_after(board_after3),
        .merge_cnt(merge_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4*TW-1:0] row4(input int c0, input int c1, input int c2, input int c3);
        logic [TW-1:0] t0, t1, t2, t3;
        t0 = TW'(c0);
        t1 = TW'(c1);
        t2 = TW'(c2);
        t3 = TW'(c3);
        return {t3, t2, t1, t0};
    endfunction

    // Called just after a rising edge; start is sampled at the next edge (E).
    task automatic launch(input logic [BW4-1:0] b, input logic [1:0] d);
        board_in = b;
        mov_dir  = d;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic launch3(input logic [BW3-1:0] b, input logic [1:0] d);
        board_in3 = b;
        mov_dir3  = d;
        start3    = 1'b1;
        @(posedge clk); #1;
        start3    = 1'b0;
    endtask

    // Returns edges elapsed since E until done is seen, or -1 on timeout.
    task automatic wait_done(input bit use3, output int cyc);
        cyc = 0;
        while (((use3 ? done3 : done) !== 1'b1) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if ((use3 ? done3 : done) !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (movable !== 1'b0) begin n_fail++; $display("FAIL rst_movable: got %b expected 0", movable); end
        n_checks++; if (board_after !== '0) begin n_fail++; $display("FAIL rst_board: got %h expected 0", board_after); end
        n_checks++; if (merge_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", merge_cnt); end
        n_checks++; if ({busy3, done3, movable3} !== 3'b000 || board_after3 !== '0) begin
            n_fail++; $display("FAIL rst_dut3: got %b/%h expected 000/0", {busy3, done3, movable3}, board_after3);
        end
    endtask

    task automatic test_move_left();
        int cyc;
        launch(brd_a, 2'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL left_busy: got %b expected 1", busy); end
        wait_done(1'b0, cyc);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL left_latency: got %0d expected 4", cyc); end
        n_checks++; if (board_after !== exp_left) begin n_fail++; $display("FAIL left_board: got %h expected %h", board_after, exp_left); end
        n_checks++; if (movable !== 1'b1) begin n_fail++; $display("FAIL left_movable: got %b expected 1", movable); end
        n_checks++; if (merge_cnt !== (SCORE ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL left_cnt: got %0d expected %0d", merge_cnt, SCORE ? 2 : 0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL left_busy_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL left_done_pulse: got %b expected 0", done); end
        n_checks++; if (board_after !== exp_left) begin n_fail++; $display("FAIL left_hold: got %h expected %h", board_after, exp_left); end
    endtask

    task automatic test_move_right();
        int cyc;
        launch(brd_a, 2'd1);
        wait_done(1'b0, cyc);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL right_latency: got %0d expected 4", cyc); end
        n_checks++; if (board_after !== exp_right) begin n_fail++; $display("FAIL right_board: got %h expected %h", board_after, exp_right); end
        n_checks++; if (movable !== 1'b1) begin n_fail++; $display("FAIL right_movable: got %b expected 1", movable); end
        n_checks++; if (merge_cnt !== (SCORE ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL right_cnt: got %0d expected %0d", merge_cnt, SCORE ? 2 : 0); end
    endtask

    task automatic test_lines();
        logic [BW4-1:0] vin  [3];
        logic [BW4-1:0] vexp [3];
        logic           vmov [3];
        int             vcnt [3];
        int             cyc;
        vin[0] = {60'd0, row4(1, 1, 1, 1)};   vexp[0] = {60'd0, row4(2, 2, 0, 0)};  vmov[0] = 1'b1; vcnt[0] = 2;
        vin[1] = {60'd0, row4(2, 2, 2, 0)};   vexp[1] = {60'd0, row4(3, 2, 0, 0)};  vmov[1] = 1'b1; vcnt[1] = 1;
        vin[2] = {60'd0, row4(31, 31, 0, 0)}; vexp[2] = {60'd0, row4(31, 31, 0, 0)}; vmov[2] = 1'b0; vcnt[2] = 0;
        for (int i = 0; i < 3; i++) begin
            launch(vin[i], 2'd0);
            wait_done(1'b0, cyc);
            n_checks++; if (board_after !== vexp[i]) begin n_fail++; $display("FAIL line%0d_board: got %h expected %h", i, board_after, vexp[i]); end
            n_checks++; if (movable !== vmov[i]) begin n_fail++; $display("FAIL line%0d_movable: got %b expected %b", i, movable, vmov[i]); end
            n_checks++; if (int'(merge_cnt) != (SCORE ? vcnt[i] : 0)) begin n_fail++; $display("FAIL line%0d_cnt: got %0d expected %0d", i, merge_cnt, SCORE ? vcnt[i] : 0); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_capture();
        int             ndone;
        int             at;
        logic [BW4-1:0] got;
        ndone = 0;
        at    = -1;
        got   = '0;
        launch(brd_a, 2'd0);
        board_in = {60'd0, row4(1, 1, 1, 1)};
        mov_dir  = 2'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (at < 0) begin at = k; got = board_after; end
            end
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL capture_pulses: got %0d expected 1", ndone); end
        n_checks++; if (at != 4) begin n_fail++; $display("FAIL capture_latency: got %0d expected 4", at); end
        n_checks++; if (got !== exp_left) begin n_fail++; $display("FAIL capture_board: got %h expected %h", got, exp_left); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(brd_a, 2'd0);
        wait_done(1'b0, cyc);
        n_checks++; if (board_after !== exp_left) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", board_after, exp_left); end
        board_in = brd_a;
        mov_dir  = 2'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        wait_done(1'b0, cyc);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 4", cyc); end
        n_checks++; if (board_after !== exp_right) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", board_after, exp_right); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        int cyc;
        ndone = 0;
        launch(brd_a, 2'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (movable !== 1'b0) begin n_fail++; $display("FAIL midrst_movable: got %b expected 0", movable); end
        n_checks++; if (board_after !== '0) begin n_fail++; $display("FAIL midrst_board: got %h expected 0", board_after); end
        n_checks++; if (merge_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", merge_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        launch(brd_a, 2'd1);
        wait_done(1'b0, cyc);
        n_checks++; if (board_after !== exp_right || cyc != 4) begin
            n_fail++; $display("FAIL midrst_recover: got %h/%0d expected %h/4", board_after, cyc, exp_right);
        end
    endtask

    task automatic test_size3();
        logic [BW3-1:0] b3;
        logic [BW3-1:0] e3;
        int             cyc;
        b3 = '0;
        b3[4:0]   = 5'd1;
        b3[19:15] = 5'd1;
        b3[34:30] = 5'd2;
        e3 = '0;
        e3[4:0]   = 5'd2;
        e3[19:15] = 5'd2;
        launch3(b3, 2'd2);
        wait_done(1'b1, cyc);
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL s3_latency: got %0d expected 3", cyc); end
        n_checks++; if (board_after3 !== e3) begin n_fail++; $display("FAIL s3_board: got %h expected %h", board_after3, e3); end
        n_checks++; if (movable3 !== 1'b1) begin n_fail++; $display("FAIL s3_movable: got %b expected 1", movable3); end
        n_checks++; if (merge_cnt3 !== (SCORE ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL s3_cnt: got %0d expected %0d", merge_cnt3, SCORE ? 1 : 0); end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        board_in  = '0;
        mov_dir   = 2'd0;
        start3    = 1'b0;
        board_in3 = '0;
        mov_dir3  = 2'd0;
        brd_a     = {row4(0, 0, 0, 3), row4(0, 0, 0, 0), row4(3, 3, 2, 1), row4(1, 2, 2, 1)};
        exp_left  = {row4(3, 0, 0, 0), row4(0, 0, 0, 0), row4(4, 2, 1, 0), row4(1, 3, 1, 0)};
        exp_right = {row4(0, 0, 0, 3), row4(0, 0, 0, 0), row4(0, 4, 2, 1), row4(0, 1, 3, 1)};
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_move_left();
        test_move_right();
        test_lines();
        test_capture();
        test_back_to_back();
        test_reset_mid_run();
        test_size3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
